// File: rtl/rgb_value_pkg.sv
// Shared constants, FSM state type and small helpers for the RGB value display digit scanner.
package rgb_value_pkg;

  localparam int         GLYPH_H    = 16;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         DD_ITER    = 8;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  // Widened by one bit so a band near the top of the 10-bit count cannot wrap.
  function automatic logic in_band(input logic [9:0] v, input logic [9:0] y0);
    return ({1'b0, v} >= {1'b0, y0}) && ({1'b0, v} < ({1'b0, y0} + 11'(GLYPH_H)));
  endfunction

  function automatic logic [11:0] blank_lead(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    if (bcd[11:8] == 4'd0) begin
      res[11:8] = BLANK_CODE;
      if (bcd[7:4] == 4'd0) res[7:4] = BLANK_CODE;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: add-3 correction on each BCD nibble, then shift left.
module bcd_dabble_step
  import rgb_value_pkg::*;
(
  input  logic [19:0] din,
  output logic [19:0] dout
);

  logic [19:0] corr;

  always_comb begin
    corr = din;
    for (int n = 0; n < 3; n++) begin
      if (din[8 + 4*n +: 4] >= 4'd5) corr[8 + 4*n +: 4] = din[8 + 4*n +: 4] + 4'd3;
    end
    dout = corr << 1;
  end

endmodule

// File: rtl/rgb_digit_scanner.sv
// Per-frame binary-to-BCD conversion of R/G/B values plus registered glyph row addressing.
// Optional macro BLANK_LEADING_ZERO_EN replaces leading zero digits with the blank glyph code.
module rgb_digit_scanner
  import rgb_value_pkg::*;
#(
  parameter int R_Y0 = 100,
  parameter int G_Y0 = 140,
  parameter int B_Y0 = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [7:0] val_r,
  input  logic [7:0] val_g,
  input  logic [7:0] val_b,
  input  logic [9:0] vcnt,
  output logic       busy,
  output logic [3:0] dig_R_h, dig_R_d, dig_R_u,
  output logic [3:0] dig_G_h, dig_G_d, dig_G_u,
  output logic [3:0] dig_B_h, dig_B_d, dig_B_u,
  output logic [3:0] addr_R_h, addr_R_d, addr_R_u,
  output logic [3:0] addr_G_h, addr_G_d, addr_G_u,
  output logic [3:0] addr_B_h, addr_B_d, addr_B_u,
  output logic       row_vld_R,
  output logic       row_vld_G,
  output logic       row_vld_B
);

  localparam logic [9:0] Y0_V [3] = '{10'(R_Y0), 10'(G_Y0), 10'(B_Y0)};

  state_e      state_q, state_d;
  logic [19:0] work_q, work_d;
  logic [2:0]  iter_q, iter_d;
  logic [1:0]  chan_q, chan_d;
  logic [7:0]  shadow_g_q, shadow_g_d;
  logic [7:0]  shadow_b_q, shadow_b_d;
  logic [11:0] tmp_q [3];
  logic [11:0] tmp_d [3];
  logic [11:0] dig_q [3];
  logic [11:0] dig_d [3];
  logic [3:0]  addr_q [3];
  logic [3:0]  addr_d [3];
  logic [2:0]  vld_q, vld_d;
  logic [19:0] step_out;

  bcd_dabble_step u_step (
    .din  (work_q),
    .dout (step_out)
  );

  // Row addressing runs every cycle, independent of the conversion FSM.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      vld_d[c]  = in_band(vcnt, Y0_V[c]);
      addr_d[c] = vld_d[c] ? 4'(vcnt - Y0_V[c]) : 4'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    iter_d     = iter_q;
    chan_d     = chan_q;
    shadow_g_d = shadow_g_q;
    shadow_b_d = shadow_b_q;
    tmp_d      = tmp_q;
    dig_d      = dig_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          shadow_g_d = val_g;
          shadow_b_d = val_b;
          work_d     = {12'd0, val_r};
          iter_d     = 3'd0;
          chan_d     = 2'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (iter_q == 3'(DD_ITER - 1)) begin
          tmp_d[chan_q] = step_out[19:8];
          iter_d        = 3'd0;
          if (chan_q == 2'd2) begin
            state_d = COMMIT;
          end else begin
            chan_d = chan_q + 2'd1;
            work_d = {12'd0, (chan_q == 2'd0) ? shadow_g_q : shadow_b_q};
          end
        end else begin
          work_d = step_out;
          iter_d = iter_q + 3'd1;
        end
      end
      COMMIT: begin
        // All nine digits update on the same edge so a frame never mixes old and new values.
        for (int c = 0; c < 3; c++) begin
`ifdef BLANK_LEADING_ZERO_EN
          dig_d[c] = blank_lead(tmp_q[c]);
`else
          dig_d[c] = tmp_q[c];
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      iter_q     <= '0;
      chan_q     <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      tmp_q      <= '{default: '0};
      dig_q      <= '{default: '0};
      addr_q     <= '{default: '0};
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      iter_q     <= iter_d;
      chan_q     <= chan_d;
      shadow_g_q <= shadow_g_d;
      shadow_b_q <= shadow_b_d;
      tmp_q      <= tmp_d;
      dig_q      <= dig_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
    end
  end

  assign busy = (state_q != IDLE);

  assign {dig_R_h, dig_R_d, dig_R_u} = dig_q[0];
  assign {dig_G_h, dig_G_d, dig_G_u} = dig_q[1];
  assign {dig_B_h, dig_B_d, dig_B_u} = dig_q[2];

  assign {addr_R_h, addr_R_d, addr_R_u} = {3{addr_q[0]}};
  assign {addr_G_h, addr_G_d, addr_G_u} = {3{addr_q[1]}};
  assign {addr_B_h, addr_B_d, addr_B_u} = {3{addr_q[2]}};

  assign row_vld_R = vld_q[0];
  assign row_vld_G = vld_q[1];
  assign row_vld_B = vld_q[2];

endmodule

// File: tb/tb_rgb_digit_scanner.sv
// Self-checking bench for rgb_digit_scanner: random values and scanlines against a decimal/arithmetic model.
// Honours BLANK_LEADING_ZERO_EN in the expected digits when the macro is defined.
module tb_rgb_digit_scanner;

  localparam int R_Y0 = 100;
  localparam int G_Y0 = 140;
  localparam int B_Y0 = 180;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [7:0] val_r, val_g, val_b;
  logic [9:0] vcnt;
  logic       busy;
  logic [3:0] dig_R_h, dig_R_d, dig_R_u, dig_G_h, dig_G_d, dig_G_u, dig_B_h, dig_B_d, dig_B_u;
  logic [3:0] addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u, addr_B_h, addr_B_d, addr_B_u;
  logic       row_vld_R, row_vld_G, row_vld_B;

  int          total = 0;
  int          bad = 0;
  bit          rand_vcnt = 1'b0;
  logic [35:0] exp_dig = '0;
  logic [35:0] dig_all;

  rgb_digit_scanner #(.R_Y0(R_Y0), .G_Y0(G_Y0), .B_Y0(B_Y0)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .val_r(val_r), .val_g(val_g), .val_b(val_b), .vcnt(vcnt), .busy(busy),
    .dig_R_h(dig_R_h), .dig_R_d(dig_R_d), .dig_R_u(dig_R_u),
    .dig_G_h(dig_G_h), .dig_G_d(dig_G_d), .dig_G_u(dig_G_u),
    .dig_B_h(dig_B_h), .dig_B_d(dig_B_d), .dig_B_u(dig_B_u),
    .addr_R_h(addr_R_h), .addr_R_d(addr_R_d), .addr_R_u(addr_R_u),
    .addr_G_h(addr_G_h), .addr_G_d(addr_G_d), .addr_G_u(addr_G_u),
    .addr_B_h(addr_B_h), .addr_B_d(addr_B_d), .addr_B_u(addr_B_u),
    .row_vld_R(row_vld_R), .row_vld_G(row_vld_G), .row_vld_B(row_vld_B)
  );

  always #5 clk = ~clk;

  assign dig_all = {dig_R_h, dig_R_d, dig_R_u, dig_G_h, dig_G_d, dig_G_u, dig_B_h, dig_B_d, dig_B_u};

  function automatic logic [11:0] dig_model(input int v);
    logic [3:0] h, d, u;
    h = 4'(v / 100);
    d = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef BLANK_LEADING_ZERO_EN
    if (v < 100) h = 4'hF;
    if (v < 10)  d = 4'hF;
`endif
    return {h, d, u};
  endfunction

  function automatic logic [12:0] row_model(input int v, input int y0);
    if (v >= y0 && v <= y0 + 15) return {1'b1, {3{4'(v - y0)}}};
    return 13'd0;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, check the registered row outputs against the scanline that edge sampled.
  task automatic apply_stimulus();
    int   pv;
    logic pr;
    pv = int'(vcnt);
    pr = reset;
    @(posedge clk);
    #1;
    check_output("row_R", {row_vld_R, addr_R_h, addr_R_d, addr_R_u}, pr ? 13'd0 : row_model(pv, R_Y0));
    check_output("row_G", {row_vld_G, addr_G_h, addr_G_d, addr_G_u}, pr ? 13'd0 : row_model(pv, G_Y0));
    check_output("row_B", {row_vld_B, addr_B_h, addr_B_d, addr_B_u}, pr ? 13'd0 : row_model(pv, B_Y0));
    if (rand_vcnt)
      vcnt = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(90, 205));
  endtask

  // Pulse frame_start now (cycle k) and follow the conversion through cycle k+26.
  task automatic convert(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit spurious);
    logic [35:0] new_d;
    new_d = {dig_model(int'(r)), dig_model(int'(g)), dig_model(int'(b))};
    val_r = r;
    val_g = g;
    val_b = b;
    frame_start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      apply_stimulus();
      frame_start = 1'b0;
      if (c <= 25) begin
        check_output("busy_conv", busy, 1'b1);
        check_output("dig_hold", dig_all, exp_dig);
      end else begin
        check_output("busy_done", busy, 1'b0);
        check_output("dig_new", dig_all, new_d);
      end
      val_r = 8'($urandom);
      val_g = 8'($urandom);
      val_b = 8'($urandom);
      if (spurious && c == 10) begin
        val_r = 8'd0;
        frame_start = 1'b1;
      end
    end
    exp_dig = new_d;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    val_r = '0;
    val_g = '0;
    val_b = '0;
    vcnt = '0;

    repeat (3) apply_stimulus();
    reset = 1'b0;
    apply_stimulus();
    check_output("rst_dig", dig_all, 36'd0);
    check_output("rst_busy", busy, 1'b0);
    rand_vcnt = 1'b1;

    vcnt = 10'(R_Y0 + 5);
    apply_stimulus();
    check_output("addr_R_in", {row_vld_R, addr_R_h, addr_R_d, addr_R_u}, {1'b1, 12'h555});
    vcnt = 10'(R_Y0 + 16);
    apply_stimulus();
    check_output("addr_R_out", {row_vld_R, addr_R_u}, 5'd0);
    vcnt = 10'(G_Y0);
    apply_stimulus();
    check_output("addr_G_top", {row_vld_G, addr_G_u}, {1'b1, 4'd0});
    vcnt = 10'(B_Y0 + 15);
    apply_stimulus();
    check_output("addr_B_last", {row_vld_B, addr_B_h}, {1'b1, 4'd15});
    vcnt = 10'(R_Y0 - 1);
    apply_stimulus();
    vcnt = 10'd1023;
    apply_stimulus();

    convert(8'd255, 8'd128, 8'd7, 1'b1);
    check_output("dig_R_255", dig_all[35:24], dig_model(255));
    convert(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    convert(8'd7, 8'd0, 8'd40, 1'b0);
`ifdef BLANK_LEADING_ZERO_EN
    check_output("blank_set", dig_all, 36'hFF7_FF0_F40);
`else
    check_output("noblank_set", dig_all, 36'h007_000_040);
`endif

    val_r = 8'd199;
    val_g = 8'd42;
    val_b = 8'd3;
    frame_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      apply_stimulus();
      frame_start = 1'b0;
      check_output("busy_pre_rst", busy, 1'b1);
    end
    reset = 1'b1;
    apply_stimulus();
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_dig", dig_all, 36'd0);
    reset = 1'b0;
    exp_dig = '0;
    repeat (30) begin
      apply_stimulus();
      check_output("no_commit_busy", busy, 1'b0);
      check_output("no_commit_dig", dig_all, 36'd0);
    end

    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 3)) apply_stimulus();
      convert(8'($urandom), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end
    convert(8'd0, 8'd9, 8'd100, 1'b0);
    convert(8'd99, 8'd10, 8'd255, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
